// File: rtl/mcycle_unit.sv
// Iterative multiply/divide engine: shift-add multiply, restoring divide, one bit per cycle.
// Optional macro MCYCLE_SIGNED_DIV_EN makes divide two's complement (sign fix-up on result load).
module mcycle_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             Start,
  input  logic             MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done
);

  // state     | meaning
  // S_IDLE    | waiting for Start; operands latched on accept
  // S_COMPUTING | WIDTH iterations, then results loaded
  // S_DONE    | Done pulse for one cycle, back to idle

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_COMPUTING = 2'd1,
    S_DONE      = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_count;
  logic             r_op;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opnd2;
  logic             w_last;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;
  logic [WIDTH-1:0] w_res1;
  logic [WIDTH-1:0] w_res2;
  logic [WIDTH-1:0] w_dividend;
  logic [WIDTH-1:0] w_divisor;

`ifdef MCYCLE_SIGNED_DIV_EN
  logic r_neg_q;
  logic r_neg_r;

  assign w_dividend = Operand1[WIDTH-1] ? -Operand1 : Operand1;
  assign w_divisor  = Operand2[WIDTH-1] ? -Operand2 : Operand2;
`else
  assign w_dividend = Operand1;
  assign w_divisor  = Operand2;
`endif

  assign w_last = (r_count == CW'(WIDTH));

  // Multiply: {r_hi, r_lo} holds partial product over the shifting multiplier
  assign w_mul_sum = r_lo[0] ? ({1'b0, r_hi} + {1'b0, r_opnd2}) : {1'b0, r_hi};

  // Divide: r_hi is the partial remainder, r_lo shifts dividend out and quotient in
  assign w_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_opnd2});
  assign w_diff  = w_shift[WIDTH-1:0] - r_opnd2;

  always_comb begin
    w_hi_nxt = w_mul_sum[WIDTH:1];
    w_lo_nxt = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    if (r_op) begin
      w_hi_nxt = w_ge ? w_diff : w_shift[WIDTH-1:0];
      w_lo_nxt = {r_lo[WIDTH-2:0], w_ge};
    end
  end

  always_comb begin
    w_res1 = r_lo;
    w_res2 = r_hi;
`ifdef MCYCLE_SIGNED_DIV_EN
    if (r_op) begin
      if (r_neg_q) w_res1 = -r_lo;
      if (r_neg_r) w_res2 = -r_hi;
    end
`endif
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state <= S_IDLE;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      Busy    <= w_busy_nxt;
      Done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (Start) w_state_nxt = S_COMPUTING;
      S_COMPUTING: if (w_last) w_state_nxt = S_DONE;
      S_DONE:      w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_count <= '0;
      r_op    <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_opnd2 <= '0;
      Result1 <= '0;
      Result2 <= '0;
`ifdef MCYCLE_SIGNED_DIV_EN
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_count <= '0;
            r_op    <= MCycleOp;
            r_hi    <= '0;
            if (MCycleOp) begin
              r_lo    <= w_dividend;
              r_opnd2 <= w_divisor;
            end else begin
              r_lo    <= Operand2;
              r_opnd2 <= Operand1;
            end
`ifdef MCYCLE_SIGNED_DIV_EN
            // zero divisor keeps the raw all-ones quotient
            r_neg_q <= (Operand1[WIDTH-1] ^ Operand2[WIDTH-1]) && (Operand2 != '0);
            r_neg_r <= Operand1[WIDTH-1];
`endif
          end
        end
        S_COMPUTING: begin
          if (w_last) begin
            Result1 <= w_res1;
            Result2 <= w_res2;
          end else begin
            r_count <= r_count + 1'b1;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mcycle_unit.sv
// Directed self-checking bench for mcycle_unit with hand-computed results.
module tb_mcycle_unit;
  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        Start = 1'b0;
  logic        MCycleOp = 1'b0;
  logic [31:0] Operand1 = '0;
  logic [31:0] Operand2 = '0;
  logic [31:0] Result1;
  logic [31:0] Result2;
  logic        Busy;
  logic        Done;

  int n_checks = 0;
  int n_fail   = 0;

  mcycle_unit #(.WIDTH(32)) u_dut (
    .CLK(CLK), .RESETn(RESETn), .Start(Start), .MCycleOp(MCycleOp),
    .Operand1(Operand1), .Operand2(Operand2),
    .Result1(Result1), .Result2(Result2), .Busy(Busy), .Done(Done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Start held until Done, then dropped; checks latency, Busy, pulse width and results
  task automatic do_op(input string tag, input logic op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e1, input logic [31:0] e2);
    int n;
    int busy_gaps;
    bit seen;
    @(negedge CLK);
    Start = 1'b1; MCycleOp = op; Operand1 = a; Operand2 = b;
    @(posedge CLK);
    n = 0; busy_gaps = 0; seen = 0;
    while (!seen && n < 100) begin
      @(posedge CLK);
      n++;
      @(negedge CLK);
      if (!Busy) busy_gaps++;
      if (Done) seen = 1;
    end
    Start = 1'b0;
    chk({tag, "_seen"}, 64'(seen), 64'd1);
    chk({tag, "_lat"}, 64'(n), 64'd33);
    chk({tag, "_busy"}, 64'(busy_gaps), 64'd0);
    chk({tag, "_r1"}, 64'(Result1), 64'(e1));
    chk({tag, "_r2"}, 64'(Result2), 64'(e2));
    @(negedge CLK);
    chk({tag, "_done_end"}, 64'(Done), 64'd0);
    chk({tag, "_busy_end"}, 64'(Busy), 64'd0);
    chk({tag, "_r1_hold"}, 64'(Result1), 64'(e1));
  endtask

  initial begin
    int done_cnt;
    int done_pos[2];
    logic [31:0] r1_cap[2];
    logic [31:0] r2_cap[2];

    #2;
    chk("rst_r1", 64'(Result1), 64'd0);
    chk("rst_r2", 64'(Result2), 64'd0);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);
    @(negedge CLK);
    RESETn = 1'b1;

    do_op("mul7x6", 1'b0, 32'd7, 32'd6, 32'h0000002A, 32'h0);
    do_op("mulmax", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE);
    do_op("div100_7", 1'b1, 32'd100, 32'd7, 32'd14, 32'd2);
    do_op("div5_0", 1'b1, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5);
`ifdef MCYCLE_SIGNED_DIV_EN
    do_op("div_neg7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
`else
    do_op("div_neg7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'd1);
`endif

    // reset in the middle of a multiply
    @(negedge CLK);
    Start = 1'b1; MCycleOp = 1'b0; Operand1 = 32'd1234; Operand2 = 32'd99;
    @(posedge CLK);
    repeat (10) @(posedge CLK);
    #1;
    RESETn = 1'b0;
    Start = 1'b0;
    #1;
    chk("midrst_busy", 64'(Busy), 64'd0);
    chk("midrst_done", 64'(Done), 64'd0);
    chk("midrst_r1", 64'(Result1), 64'd0);
    chk("midrst_r2", 64'(Result2), 64'd0);
    @(negedge CLK);
    RESETn = 1'b1;
    done_cnt = 0;
    repeat (40) begin
      @(negedge CLK);
      if (Done || Busy) done_cnt++;
    end
    chk("midrst_quiet", 64'(done_cnt), 64'd0);
    do_op("mul7x6_again", 1'b0, 32'd7, 32'd6, 32'h0000002A, 32'h0);

    // back-to-back with Start held and operands changed after accept
    @(negedge CLK);
    Start = 1'b1; MCycleOp = 1'b0; Operand1 = 32'd3; Operand2 = 32'd5;
    @(posedge CLK);
    #1;
    MCycleOp = 1'b1; Operand1 = 32'd100; Operand2 = 32'd7;
    done_cnt = 0;
    done_pos[0] = 0; done_pos[1] = 0;
    r1_cap[0] = '0; r1_cap[1] = '0; r2_cap[0] = '0; r2_cap[1] = '0;
    for (int n = 1; n <= 90; n++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (n == 36) Start = 1'b0;
      if (Done) begin
        if (done_cnt < 2) begin
          done_pos[done_cnt] = n;
          r1_cap[done_cnt] = Result1;
          r2_cap[done_cnt] = Result2;
        end
        done_cnt++;
      end
    end
    chk("b2b_done_cnt", 64'(done_cnt), 64'd2);
    chk("b2b_pos0", 64'(done_pos[0]), 64'd33);
    chk("b2b_pos1", 64'(done_pos[1]), 64'd68);
    chk("b2b_r1_0", 64'(r1_cap[0]), 64'd15);
    chk("b2b_r2_0", 64'(r2_cap[0]), 64'd0);
    chk("b2b_r1_1", 64'(r1_cap[1]), 64'd14);
    chk("b2b_r2_1", 64'(r2_cap[1]), 64'd2);
    chk("b2b_idle", 64'(Busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
